// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DDR2 command-port arbiter.
// Holds the FSM state encoding, port indices and default widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  localparam int DEFAULT_ADDR_W = 28;
  localparam int DEFAULT_DATA_W = 256;

  // With two ports, round-robin simply hands the tie to the other port.
  function automatic logic rr_next(input logic last_grant);
    return ~last_grant;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: chooses a port from the valid
// vector, giving ties to the port that was not granted last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       pick_valid,
  output logic       pick
);

  // Pick the single requester, or alternate on a tie.
  always_comb begin
    pick_valid = valid[0] | valid[1];
    case (valid)
      2'b01:   pick = PORT_ICACHE;
      2'b10:   pick = PORT_DCACHE;
      2'b11:   pick = rr_next(last_grant);
      default: pick = last_grant;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the DDR2 command port between icache (port 0) and dcache (port 1).
// Define MEM_ARB_TIMEOUT_EN to build the BUSY watchdog driving the sticky error output.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid0,
  input  logic              req_valid1,
  input  logic              req_rw0,
  input  logic              req_rw1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic              req_ready0,
  output logic              req_ready1,
  output logic [DATA_W-1:0] req_rdata,
  output logic              mem_valid_data,
  output logic              mem_rw_data,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic [DATA_W-1:0] mem_data_wr,
  input  logic [DATA_W-1:0] mem_data_rd,
  input  logic              mem_ready_data,
  output logic              grant,
  output logic              error
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready0_q, ready0_d;
  logic              ready1_q, ready1_d;

  logic pick_valid;
  logic pick;

  mem_arb_rr_pick u_rr_pick (
    .valid      ({req_valid1, req_valid0}),
    .last_grant (grant_q),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d     = pick;
          mem_valid_d = 1'b1;
          mem_rw_d    = pick ? req_rw1    : req_rw0;
          mem_addr_d  = pick ? req_addr1  : req_addr0;
          mem_wdata_d = pick ? req_wdata1 : req_wdata0;
          state_d     = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready_data) begin
          rdata_d     = mem_data_rd;
          mem_valid_d = 1'b0;
          ready0_d    = (grant_q == PORT_ICACHE);
          ready1_d    = (grant_q == PORT_DCACHE);
          state_d     = RESP;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          // A late completion in the same cycle wins over the watchdog.
          if (cnt_q == TIMEOUT_LIMIT) begin
            rdata_d     = {DATA_W{1'b0}};
            mem_valid_d = 1'b0;
            ready0_d    = (grant_q == PORT_ICACHE);
            ready1_d    = (grant_q == PORT_DCACHE);
            error_d     = 1'b1;
            state_d     = RESP;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= PORT_DCACHE;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      error_q     <= error_d;
`endif
    end
  end

  assign req_ready0     = ready0_q;
  assign req_ready1     = ready1_q;
  assign req_rdata      = rdata_q;
  assign mem_valid_data = mem_valid_q;
  assign mem_rw_data    = mem_rw_q;
  assign mem_data_addr  = mem_addr_q;
  assign mem_data_wr    = mem_wdata_q;
  assign grant          = grant_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected commands are queued as requests
// are issued and matched against the downstream port and the completion pulses.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 256;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  typedef struct packed {
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid0, req_valid1, req_rw0, req_rw1;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic          req_ready0, req_ready1;
  logic [DW-1:0] req_rdata;
  logic          mem_valid_data, mem_rw_data;
  logic [AW-1:0] mem_data_addr;
  logic [DW-1:0] mem_data_wr, mem_data_rd;
  logic          mem_ready_data;
  logic          grant, error;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_rw0(req_rw0), .req_rw1(req_rw1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_rdata(req_rdata),
    .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data),
    .mem_data_addr(mem_data_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd), .mem_ready_data(mem_ready_data),
    .grant(grant), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cmd_t  stim0[$], stim1[$], exp_cmd_q[$];
  resp_t exp_resp_q[$];

  int            mem_lat = 0;
  logic          mem_hold = 1'b0;
  logic          stray_req = 1'b0;
  logic          spacing_on = 1'b0;
  int            last_rise = -1;
  logic [DW-1:0] last_rdata_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    if (a == 28'h0001010)
      r = 256'h1111111122222222333333334444444455555555666666667777777788888888;
    else
      r = {8{4'h5, a}};
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic port, input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cmd_t c;
    c.port = port; c.rw = rw; c.addr = addr; c.wdata = wd;
    if (port) stim1.push_back(c); else stim0.push_back(c);
    exp_cmd_q.push_back(c);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_cmd_q.size() != 0 || exp_resp_q.size() != 0 || stim0.size() != 0 ||
                          stim1.size() != 0 || req_valid0 || req_valid1)) begin
      step(1);
      i++;
    end
    check_eq({tag, "_drain"}, DW'(exp_cmd_q.size() + exp_resp_q.size() + stim0.size() + stim1.size()), '0);
  endtask

  // Port 0 requester: holds each request until its ready pulse.
  initial begin : drv0
    cmd_t c;
    req_valid0 = 1'b0; req_rw0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) req_valid0 = 1'b0;
      else if (!req_valid0 || req_ready0) begin
        if (stim0.size() > 0) begin
          c = stim0.pop_front();
          req_valid0 = 1'b1; req_rw0 = c.rw; req_addr0 = c.addr; req_wdata0 = c.wdata;
        end else req_valid0 = 1'b0;
      end
    end
  end

  // Port 1 requester.
  initial begin : drv1
    cmd_t c;
    req_valid1 = 1'b0; req_rw1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) req_valid1 = 1'b0;
      else if (!req_valid1 || req_ready1) begin
        if (stim1.size() > 0) begin
          c = stim1.pop_front();
          req_valid1 = 1'b1; req_rw1 = c.rw; req_addr1 = c.addr; req_wdata1 = c.wdata;
        end else req_valid1 = 1'b0;
      end
    end
  end

  // Memory model: answers after mem_lat cycles, or fires a stray pulse on request.
  initial begin : mem_model
    int busy;
    busy = 0;
    mem_ready_data = 1'b0;
    mem_data_rd = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready_data = 1'b0;
      if (stray_req) begin
        mem_ready_data = 1'b1;
        mem_data_rd = '1;
        stray_req = 1'b0;
      end else if (mem_valid_data && !rst && !mem_hold) begin
        if (busy >= mem_lat) begin
          mem_ready_data = 1'b1;
          mem_data_rd = rd_pattern(mem_data_addr);
          busy = 0;
        end else busy++;
      end else busy = 0;
    end
  end

  // Monitor on the falling edge: matches commands and completions against the scoreboard.
  initial begin : monitor
    logic  acc_prev, valid_prev, any_rdy;
    cmd_t  e;
    resp_t r;
    acc_prev = 1'b0; valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_prev = 1'b0; valid_prev = 1'b0;
      end else begin
        any_rdy = req_ready0 | req_ready1;
        if (acc_prev) check_eq("ready_latency", DW'(any_rdy), DW'(1'b1));
        if (any_rdy) begin
          if (exp_resp_q.size() == 0) check_eq("ready_unexpected", DW'({req_ready1, req_ready0}), '0);
          else begin
            r = exp_resp_q.pop_front();
            check_eq("ready_port", DW'({req_ready1, req_ready0}), r.port ? DW'(2'b10) : DW'(2'b01));
            check_eq("rdata", req_rdata, r.rdata);
            check_eq("valid_low_in_resp", DW'(mem_valid_data), '0);
            last_rdata_exp = r.rdata;
          end
        end
        if (mem_valid_data && !valid_prev) begin
          if (exp_cmd_q.size() == 0) check_eq("cmd_unexpected", DW'(mem_valid_data), '0);
          else begin
            e = exp_cmd_q.pop_front();
            check_eq("grant", DW'(grant), DW'(e.port));
            check_eq("mem_rw", DW'(mem_rw_data), DW'(e.rw));
            check_eq("mem_addr", DW'(mem_data_addr), DW'(e.addr));
            check_eq("mem_wdata", mem_data_wr, e.wdata);
            if (spacing_on && last_rise >= 0) check_eq("cmd_spacing", DW'(cyc - last_rise), DW'(3));
            last_rise = cyc;
            r.port = e.port;
            r.rdata = rd_pattern(e.addr);
`ifdef MEM_ARB_TIMEOUT_EN
            if (mem_hold) r.rdata = '0;
`endif
            exp_resp_q.push_back(r);
          end
        end
        acc_prev = mem_valid_data & mem_ready_data;
        valid_prev = mem_valid_data;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int i;
    rst = 1'b1;
    step(3);
    check_eq("rst_mem_valid", DW'(mem_valid_data), '0);
    check_eq("rst_mem_rw", DW'(mem_rw_data), '0);
    check_eq("rst_mem_addr", DW'(mem_data_addr), '0);
    check_eq("rst_mem_wdata", mem_data_wr, '0);
    check_eq("rst_ready", DW'({req_ready1, req_ready0}), '0);
    check_eq("rst_rdata", req_rdata, '0);
    check_eq("rst_grant", DW'(grant), DW'(1'b1));
    check_eq("rst_error", DW'(error), '0);
    rst = 1'b0;

    // Port 0 single read, memory answers 4 cycles after valid rises.
    mem_lat = 4;
    @(negedge clk);
    send(1'b0, 1'b0, 28'h0001010, '0);
    drain("p0_read", 100);
    check_eq("p0_read_rdata_hold", req_rdata, rd_pattern(28'h0001010));

    // Both ports valid straight out of reset: port 0 write wins, then port 1 read.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    mem_lat = 0;
    @(negedge clk);
    send(1'b0, 1'b1, 28'h0000000, {8{32'hA5A5_0F0F}});
    send(1'b1, 1'b0, 28'h2000000, '0);
    drain("tie_reset", 100);
    check_eq("tie_last_grant", DW'(grant), DW'(1'b1));

    // Six back-to-back transactions with zero-latency memory: alternating grants, 3-cycle spacing.
    spacing_on = 1'b1;
    last_rise = -1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send(1'b0, k[0], AW'(28'h0100000 + k), {8{32'(k + 16)}});
      send(1'b1, ~k[0], AW'(28'h0200000 + k), {8{32'(k + 32)}});
    end
    drain("rr_stream", 200);
    spacing_on = 1'b0;

    // Stray completion while idle must be ignored.
    stray_req = 1'b1;
    step(5);
    check_eq("stray_valid", DW'(mem_valid_data), '0);
    check_eq("stray_ready", DW'({req_ready1, req_ready0}), '0);
    check_eq("stray_rdata", req_rdata, last_rdata_exp);

    // Reset in the middle of BUSY, then a late completion for the abandoned command.
    mem_hold = 1'b1;
    @(negedge clk);
    send(1'b1, 1'b0, 28'h0ABCDEF, '0);
    i = 0;
    while (i < 20 && !mem_valid_data) begin step(1); i++; end
    check_eq("busy_reached", DW'(mem_valid_data), DW'(1'b1));
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_resp_q.delete();
    exp_cmd_q.delete();
    last_rdata_exp = '0;
    check_eq("rst_busy_valid", DW'(mem_valid_data), '0);
    mem_hold = 1'b0;
    stray_req = 1'b1;
    step(6);
    check_eq("late_ready_valid", DW'(mem_valid_data), '0);
    check_eq("late_ready_rdata", req_rdata, '0);
    mem_lat = 1;
    @(negedge clk);
    send(1'b0, 1'b0, 28'h0000040, '0);
    drain("after_rst", 100);

    // Memory that never answers.
    mem_hold = 1'b1;
    @(negedge clk);
    send(1'b0, 1'b0, 28'h0033333, '0);
`ifdef MEM_ARB_TIMEOUT_EN
    drain("timeout", 100);
    check_eq("timeout_error", DW'(error), DW'(1'b1));
    mem_hold = 1'b0;
    @(negedge clk);
    send(1'b1, 1'b0, 28'h0044444, '0);
    drain("after_timeout", 100);
    check_eq("error_sticky", DW'(error), DW'(1'b1));
`else
    step(40);
    check_eq("hang_valid", DW'(mem_valid_data), DW'(1'b1));
    check_eq("hang_error", DW'(error), '0);
    mem_hold = 1'b0;
    drain("hang_release", 100);
    check_eq("no_error", DW'(error), '0);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single DDR2 memory command port between the instruction cache (port 0) and the data cache (port 1). It sits between the two caches and the DDR2 controller front end. It accepts one 256-bit read or write per requester handshake and forwards one command at a time downstream, with round-robin fairness. It returns the completion, plus read data, to the requester that owns the grant.

## Interface
- ADDR_W, 28, DDR2 line address width
- DATA_W, 256, line data width
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid0 / req_valid1  in  1  request from port 0 / port 1; held until its req_ready pulses
- req_rw0 / req_rw1  in  1  1 = write, 0 = read
- req_addr0 / req_addr1  in  ADDR_W  line address
- req_wdata0 / req_wdata1  in  DATA_W  write data
- req_ready0 / req_ready1  out  1  one-cycle completion pulse
- req_rdata  out  DATA_W  read data, shared by both ports, valid when the owning req_ready is high
- mem_valid_data  out  1  downstream command valid
- mem_rw_data  out  1  downstream 1 = write, 0 = read
- mem_data_addr  out  ADDR_W  downstream address
- mem_data_wr  out  DATA_W  downstream write data
- mem_data_rd  in  DATA_W  downstream read data, valid with mem_ready_data
- mem_ready_data  in  1  downstream completion, sampled only while mem_valid_data = 1
- grant  out  1  port index of the current or most recent grant
- error  out  1  sticky watchdog error

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: command outstanding downstream.
  - RESP: return the completion to the requester.
- IDLE behaviour:
  - If exactly one req_valid is high, grant that port.
  - If both are high, grant the port not granted last (round-robin).
  - On a grant, register the port's rw, addr and wdata onto the mem_* outputs, set mem_valid_data = 1, update grant, and go to BUSY.
- BUSY behaviour:
  - Hold all mem_* outputs stable.
  - When mem_ready_data = 1, capture mem_data_rd into req_rdata, clear mem_valid_data, pulse the granted req_readyN for the RESP cycle, and go to RESP.
- RESP behaviour:
  - Ignore req_valid and mem_ready_data.
  - Go to IDLE.
- For writes, req_rdata is still loaded with mem_data_rd; requesters must not use it.
- mem_ready_data is ignored in IDLE and RESP. A stray pulse must not change state or outputs.
- After rst in the middle of a transaction, the block is in IDLE. Any later mem_ready_data for the abandoned command is ignored.
- Reset values:
  - state = IDLE; grant = 1, so port 0 wins the first tie.
  - mem_valid_data = 0, mem_rw_data = 0, mem_data_addr = 0, mem_data_wr = 0.
  - req_ready0 = req_ready1 = 0, req_rdata = 0, error = 0.

## Timing
- Request seen in IDLE at cycle t: mem_valid_data = 1 from t+1.
- mem_ready_data sampled high at cycle t+k (k ≥ 1): req_readyN = 1 and req_rdata valid during t+k+1 only; mem_valid_data = 0 from t+k+1.
- IDLE again at t+k+2; the next grant is visible on mem_valid_data at t+k+3.
- Minimum spacing between downstream commands: 3 cycles, so at most one command every 3 cycles with zero memory latency.
- A requester may present a new request at t+k+2 (the edge after it sees ready).
- mem_ready_data in the first BUSY cycle (k = 1) completes the command.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in BUSY and clears on entry to BUSY.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready_data, set error = 1 (sticky until rst), drop mem_valid_data, go to RESP, pulse req_readyN, and set req_rdata = 0.
  - If mem_ready_data arrives in the same cycle as the timeout, the transaction completes normally and error is not set.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter is built and error is tied to 0.
  - BUSY waits indefinitely for mem_ready_data.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - port-index constants PORT_ICACHE = 0 and PORT_DCACHE = 1;
  - the default widths ADDR_W = 28 and DATA_W = 256.
- Sub-module mem_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: valid[1:0], last grant.
  - Outputs: pick_valid, pick index.

## Test plan
- Port 0 only: read, addr 28'h0001010, mem_ready_data 4 cycles after mem_valid_data rises with mem_data_rd = 256'h1111…8888 -> req_ready0 pulses once with req_rdata = 256'h1111…8888; req_ready1 stays 0.
- Both ports valid from reset: port 0 writes 28'h0000000, port 1 reads 28'h2000000 -> port 0's write is forwarded first with mem_rw_data = 1, then port 1's read with mem_rw_data = 0; grant goes 0 then 1.
- Both ports request continuously for 6 transactions with zero-latency ready -> grants alternate 0,1,0,1,0,1 and mem_valid_data rises every 3 cycles.
- Stray mem_ready_data pulse in IDLE, and rst asserted while BUSY followed by a late mem_ready_data -> no req_ready pulse, state IDLE, mem_valid_data = 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, mem_ready_data never asserted -> error = 1, req_ready pulses with req_rdata = 0, and the next request is still served. Without the macro, error stays 0 and mem_valid_data stays high.
